// File: rtl/acc_pkg.sv
// Shared types and constants for the lane accumulator.
package acc_pkg;

  // Raw encodings of the wr_mode port.
  localparam logic [1:0] MODE_OVERWRITE = 2'b00;
  localparam logic [1:0] MODE_ADD       = 2'b01;
  localparam logic [1:0] MODE_SUB       = 2'b10;

  typedef enum logic [1:0] {
    OVERWRITE = MODE_OVERWRITE,
    ADD       = MODE_ADD,
    SUB       = MODE_SUB
  } acc_mode_e;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} clear_state_e;

  // Highest index of the write pipeline valid shift register.
  localparam int STAGES = 3;

  // The reserved encoding 2'b11 behaves as an overwrite.
  function automatic acc_mode_e decode_mode(input logic [1:0] m);
    case (m)
      MODE_ADD: return ADD;
      MODE_SUB: return SUB;
      default:  return OVERWRITE;
    endcase
  endfunction

endpackage

// File: rtl/lane_accumulator_if.sv
// Write, read and clear handshake bundle of the lane accumulator.
interface lane_accumulator_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            wr_mode;
  logic                  wr_ready;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  clear_start;
  logic                  clear_busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mode, rd_en, rd_addr, clear_start,
    input  wr_ready, rd_data, rd_valid, clear_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mode, rd_en, rd_addr, clear_start,
    output wr_ready, rd_data, rd_valid, clear_busy
  );
endinterface

// File: rtl/acc_lane_alu.sv
// One lane of the modular overwrite/add/subtract datapath.
module acc_lane_alu
  import acc_pkg::*;
#(
  parameter int LANE_WIDTH = 16,
  parameter int LOG_Q      = 16
) (
  input  acc_mode_e             mode,
  input  logic [LANE_WIDTH-1:0] old_val,
  input  logic [LANE_WIDTH-1:0] op_val,
  output logic [LANE_WIDTH-1:0] res
);
  // Wrapping LANE_WIDTH arithmetic then masking gives mod 2**LOG_Q and
  // forces the bits above LOG_Q to zero.
  localparam logic [LANE_WIDTH-1:0] MASK = {LANE_WIDTH{1'b1}} >> (LANE_WIDTH - LOG_Q);

  // Select the lane result for the requested operation.
  always_comb begin
    case (mode)
      ADD:     res = (old_val + op_val) & MASK;
      SUB:     res = (old_val - op_val) & MASK;
      default: res = op_val & MASK;
    endcase
  end
endmodule

// File: rtl/lane_accumulator.sv
// Multi-lane read-modify-write accumulator RAM with forwarding and bulk clear.
module lane_accumulator
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int LANE_WIDTH = 16,
  parameter int LOG_Q      = 16
) (
  input logic               clk,
  input logic               rstn,
  lane_accumulator_if.slave bus
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [LANES-1:0][LANE_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0]            addr_t;
  typedef struct packed { addr_t addr; acc_mode_e mode; word_t op; } wr_req_t;
  typedef struct packed { addr_t addr; word_t data; } wb_t;

  // Two identically written simple dual-port copies: one feeds the external
  // read port, the other the read-modify-write pipeline, so neither stalls.
  word_t mem_rd  [DEPTH];
  word_t mem_rmw [DEPTH];

  // [0] accepted, [1] RAM read, [2] result awaiting write-back, [3] just written
  logic [STAGES:0] vld_pipe;
  wr_req_t         s0, s1;
  wb_t             s2, s3;
  word_t           rmw_q, old_word, new_word;

  clear_state_e state;
  addr_t        clr_addr;
  logic         wr_ready_q, clear_busy_q;

  logic  rd_pend, rd_valid_q;
  word_t rd_q, rd_data_q;

  logic  ram_we;
  addr_t ram_waddr;
  word_t ram_wdata;
  logic  wr_acc, rd_acc;

  assign wr_acc = bus.wr_en & wr_ready_q;
  assign rd_acc = bus.rd_en & ~clear_busy_q;

  assign bus.wr_ready   = wr_ready_q;
  assign bus.clear_busy = clear_busy_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;

  // Write pipeline occupancy shifts one stage per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], wr_acc};
  end

  // Write pipeline payload; qualified by vld_pipe so no reset is needed.
  always_ff @(posedge clk) begin
    s0    <= '{addr: bus.wr_addr, mode: decode_mode(bus.wr_mode), op: bus.wr_data};
    s1    <= s0;
    rmw_q <= mem_rmw[s0.addr];
    s2    <= '{addr: s1.addr, data: new_word};
    s3    <= s2;
  end

  // The RAM word misses the write about to land (s2) and the one that
  // landed on the same edge as the read (s3); the newest match wins.
  always_comb begin
    old_word = rmw_q;
    if (vld_pipe[2] && s2.addr == s1.addr)      old_word = s2.data;
    else if (vld_pipe[3] && s3.addr == s1.addr) old_word = s3.data;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    acc_lane_alu #(.LANE_WIDTH(LANE_WIDTH), .LOG_Q(LOG_Q)) u_alu (
      .mode    (s1.mode),
      .old_val (old_word[l]),
      .op_val  (s1.op[l]),
      .res     (new_word[l])
    );
  end

  // Write port: clear sweep owns it in CLEAR, otherwise pipeline write-back.
  always_comb begin
    ram_we    = vld_pipe[2];
    ram_waddr = s2.addr;
    ram_wdata = s2.data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_addr;
      ram_wdata = '0;
    end
  end

  // Both copies take every write; reads elsewhere see pre-write data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_rd[ram_waddr]  <= ram_wdata;
      mem_rmw[ram_waddr] <= ram_wdata;
    end
  end

  // Clear FSM: drain in-flight writes, then zero one word per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      clr_addr     <= '0;
      clear_busy_q <= 1'b0;
      wr_ready_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wr_ready_q <= 1'b1;
          if (bus.clear_start) begin
            state        <= DRAIN;
            clear_busy_q <= 1'b1;
            wr_ready_q   <= 1'b0;
          end
        end
        DRAIN: begin
          if (vld_pipe[2:0] == '0) begin
            state    <= CLEAR;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == addr_t'(DEPTH - 1)) begin
            state        <= IDLE;
            clear_busy_q <= 1'b0;
            wr_ready_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered RAM read for the external port.
  always_ff @(posedge clk) begin
    rd_q <= mem_rd[bus.rd_addr];
  end

  // Output stage: rd_data only moves when a read completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_pend    <= rd_acc;
      rd_valid_q <= rd_pend;
      if (rd_pend) rd_data_q <= rd_q;
    end
  end

endmodule

// File: tb/tb_lane_accumulator.sv
// Self-checking bench: directed cases plus randomized traffic against a
// sequential-application reference model.
module tb_lane_accumulator;
  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int LW    = 16;
  localparam int LQ    = 15;
  localparam int LANES = DW / LW;
  localparam int DEPTH = 1 << AW;
  localparam int Q     = 1 << LQ;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lane_accumulator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  lane_accumulator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW), .LOG_Q(LQ)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct { int cyc; int addr; logic [1:0] mode; logic [DW-1:0] data; } wr_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  bit m_clr  = 1'b0;
  bit use_const = 1'b0;
  logic [DW-1:0] const_val = '0;
  logic [DW-1:0] last_rd   = '0;
  logic [DW-1:0] model [DEPTH];
  wr_t pw[$];
  rd_t er[$];

  function automatic logic [DW-1:0] rep(input logic [LW-1:0] v);
    return {LANES{v}};
  endfunction

  // Reference: each lane is an integer mod Q.
  function automatic logic [DW-1:0] apply_op(input logic [DW-1:0] old, input logic [1:0] mode,
                                             input logic [DW-1:0] op);
    logic [DW-1:0] r;
    int a, b, v;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      a = int'(old[l*LW +: LW]);
      b = int'(op[l*LW +: LW]);
      case (mode)
        2'b01:   v = (a + b) % Q;
        2'b10:   v = ((a - b) % Q + Q) % Q;
        default: v = b % Q;
      endcase
      r[l*LW +: LW] = LW'(v);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptances, retire writes 4+ cycles old into the
  // model, then check the read port #1 after the edge.
  task automatic tick();
    bit  wacc, racc;
    int  ra;
    wr_t w;
    rd_t e;
    wacc = bus.wr_en && !m_clr;
    racc = bus.rd_en && !m_clr;
    ra   = int'(bus.rd_addr);
    w    = '{0, int'(bus.wr_addr), bus.wr_mode, bus.wr_data};
    @(posedge clk);
    cyc++;
    if (wacc) begin
      w.cyc = cyc;
      pw.push_back(w);
    end
    while (pw.size() > 0 && pw[0].cyc <= cyc - 4) begin
      w = pw.pop_front();
      model[w.addr] = apply_op(model[w.addr], w.mode, w.data);
    end
    if (racc) begin
      e.due  = cyc + 1;
      e.data = use_const ? const_val : model[ra];
      er.push_back(e);
    end
    #1;
    if (er.size() > 0 && er[0].due == cyc) begin
      e = er.pop_front();
      chk("rd_valid", DW'(bus.rd_valid), DW'(1));
      chk("rd_data", bus.rd_data, e.data);
      last_rd = e.data;
    end else begin
      chk("rd_valid_idle", DW'(bus.rd_valid), DW'(0));
      chk("rd_data_hold", bus.rd_data, last_rd);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int a, input logic [1:0] m, input logic [DW-1:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(a); bus.wr_mode = m; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_issue(input int a, input logic [DW-1:0] v);
    bus.rd_en = 1'b1; bus.rd_addr = AW'(a); use_const = 1'b1; const_val = v;
    tick();
    bus.rd_en = 1'b0; use_const = 1'b0;
  endtask

  task automatic rd_const(input int a, input logic [DW-1:0] v);
    rd_issue(a, v);
    tick();
  endtask

  // Clear from IDLE with an empty pipeline; writes are attempted throughout.
  task automatic clear_ram(input bit with_read);
    bus.clear_start = 1'b1; bus.rd_en = with_read; bus.rd_addr = AW'(8'h10);
    tick();
    bus.clear_start = 1'b0; bus.rd_en = 1'b0;
    chk("busy_start", DW'(bus.clear_busy), DW'(1));
    chk("wr_ready_start", DW'(bus.wr_ready), DW'(0));
    m_clr = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      bus.wr_en = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_mode = 2'b00;
      bus.wr_data = {$urandom, $urandom} | 64'h1;
      bus.rd_en = 1'($urandom_range(0, 1)); bus.rd_addr = AW'($urandom);
      bus.clear_start = (k == 20);
      tick();
      if (k <= DEPTH) begin
        chk("busy_during", DW'(bus.clear_busy), DW'(1));
        chk("wr_ready_during", DW'(bus.wr_ready), DW'(0));
      end
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clear_start = 1'b0; m_clr = 1'b0;
    chk("busy_end", DW'(bus.clear_busy), DW'(0));
    chk("wr_ready_end", DW'(bus.wr_ready), DW'(1));
    foreach (model[i]) model[i] = '0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mode = 2'b00;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.clear_start = 1'b0;

    // Reset state
    #3;
    chk("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_busy", DW'(bus.clear_busy), DW'(0));
    #9 rstn = 1'b1;
    tick();
    chk("wr_ready_after_rst", DW'(bus.wr_ready), DW'(1));

    // Known RAM contents to start from
    clear_ram(1'b0);

    // Overwrite 100 then add 50; read at the first visible edge
    wr(8'h10, 2'b00, rep(16'd100));
    wr(8'h10, 2'b01, rep(16'd50));
    idle(3);
    rd_const(8'h10, rep(16'd150));

    // Visibility boundary: t+3 sees old value, t+4 sees new
    wr(8'h40, 2'b00, rep(16'd9));
    idle(2);
    rd_issue(8'h40, '0);
    rd_issue(8'h40, rep(16'd9));
    idle(1);

    // Four back-to-back adds to one address
    wr(8'h50, 2'b00, '0);
    repeat (4) wr(8'h50, 2'b01, rep(16'd10));
    idle(3);
    rd_const(8'h50, rep(16'd40));

    // Modulus 2**15 wrap cases and reserved mode
    wr(8'h30, 2'b00, rep(16'hFFFF));
    idle(3);
    rd_const(8'h30, rep(16'h7FFF));
    wr(8'h30, 2'b01, rep(16'd1));
    idle(3);
    rd_const(8'h30, '0);
    wr(8'h30, 2'b10, rep(16'd1));
    idle(3);
    rd_const(8'h30, rep(16'h7FFF));
    wr(8'h31, 2'b11, rep(16'h8005));
    idle(3);
    rd_const(8'h31, rep(16'h0005));

    // Interleaved adds to two addresses
    wr(8'h10, 2'b01, rep(16'd10));
    wr(8'h20, 2'b01, rep(16'd20));
    wr(8'h10, 2'b01, rep(16'd5));
    idle(3);
    rd_const(8'h10, rep(16'd165));
    rd_const(8'h20, rep(16'd20));

    // Random mixed traffic on a few hot addresses
    for (int i = 0; i < 400; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) != 0);
      bus.wr_addr = AW'($urandom_range(0, 7));
      bus.wr_mode = 2'($urandom_range(0, 3));
      bus.wr_data = {$urandom, $urandom};
      bus.rd_en   = 1'($urandom_range(0, 1));
      bus.rd_addr = AW'($urandom_range(0, 7));
      tick();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    idle(5);

    // Clear with a read in flight, then every address reads zero
    clear_ram(1'b1);
    for (int a = 0; a < DEPTH; a++) rd_issue(a, '0);
    idle(1);

    // Reset in the middle of a clear
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    m_clr = 1'b1;
    idle(10);
    #2 rstn = 1'b0;
    #1;
    chk("midclr_busy", DW'(bus.clear_busy), DW'(0));
    chk("midclr_rd_valid", DW'(bus.rd_valid), DW'(0));
    chk("midclr_rd_data", bus.rd_data, '0);
    #3 rstn = 1'b1;
    m_clr = 1'b0; pw.delete(); er.delete(); last_rd = '0;
    tick();
    chk("post_rst_wr_ready", DW'(bus.wr_ready), DW'(1));
    chk("post_rst_busy", DW'(bus.clear_busy), DW'(0));
    wr(5, 2'b00, rep(16'd7));
    idle(3);
    rd_const(5, rep(16'd7));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lane_accumulator.md
LANE_ACCUMULATOR -- requirements
Module: lane_accumulator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, meaning RAM address bits (depth = 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning word width; an integer multiple of LANE_WIDTH.
REQ-003 SHALL have parameter LANE_WIDTH, default 16, meaning independent lane width within a word.
REQ-004 SHALL have parameter LOG_Q, default 16, meaning modulus exponent per lane; 1 <= LOG_Q <= LANE_WIDTH.
REQ-005 SHALL have port clk  in  1  single clock.
REQ-006 SHALL have port rstn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  in  1  write/accumulate request.
REQ-008 SHALL have port wr_addr  in  ADDR_WIDTH  target word.
REQ-009 SHALL have port wr_data  in  DATA_WIDTH  operand, LANES = DATA_WIDTH/LANE_WIDTH lanes.
REQ-010 SHALL have port wr_mode  in  2  00 overwrite, 01 add, 10 subtract, 11 reserved (treated as overwrite).
REQ-011 SHALL have port wr_ready  out  1  write accepted when wr_en && wr_ready at a rising edge.
REQ-012 SHALL have port rd_en  in  1  read request.
REQ-013 SHALL have port rd_addr  in  ADDR_WIDTH  read word.
REQ-014 SHALL have port rd_data  out  DATA_WIDTH  read result.
REQ-015 SHALL have port rd_valid  out  1  rd_data qualifier.
REQ-016 SHALL have port clear_start  in  1  one-cycle pulse to zero the whole RAM.
REQ-017 SHALL have port clear_busy  out  1  high while the clear FSM is not IDLE.

Function
REQ-018 Write pipeline SHALL be 4 stages: accept, RAM read, per-lane compute, RAM write-back; one accepted write per cycle sustained.
REQ-019 Per lane, add SHALL store (old + op) mod 2**LOG_Q, subtract (old - op) mod 2**LOG_Q, overwrite op mod 2**LOG_Q; lane bits above LOG_Q SHALL be stored as 0.
REQ-020 Back-to-back writes to any address mix SHALL produce the same RAM contents as sequential application in acceptance order, via forwarding from compute/write-back stages.
REQ-021 Read accepted when rd_en high and clear_busy low SHALL assert rd_valid exactly 2 cycles later with the word; otherwise rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-022 A write accepted at edge t SHALL be visible to reads accepted at edge t+4 or later; reads at t..t+3 SHALL return the pre-write value.
REQ-023 Simultaneous read and write to the same or different addresses SHALL both be served with no stall.
REQ-024 Clear FSM SHALL have states IDLE, DRAIN, CLEAR; IDLE --clear_start--> DRAIN; DRAIN --write pipeline empty--> CLEAR; CLEAR writes 0 to address 0..depth-1, one per cycle, then --> IDLE.
REQ-025 wr_ready SHALL be 0 in DRAIN and CLEAR, else 1; clear_start outside IDLE SHALL be ignored.
REQ-026 A clear from IDLE with empty pipeline SHALL keep clear_busy high for exactly depth+1 cycles.
REQ-027 Reads pending when clear_start arrives SHALL still complete with rd_valid.

Reset
REQ-028 On rstn low, asynchronously: rd_valid=0, rd_data=0, clear_busy=0, FSM=IDLE, all stage valids=0; wr_ready SHALL be 1 from the first edge after release.
REQ-029 RAM contents SHALL NOT be reset; reset mid-clear or mid-pipeline SHALL abort, and in-flight writes may be lost.

Structure
REQ-030 Package acc_pkg SHALL hold the acc_mode_e typedef (OVERWRITE, ADD, SUB), the clear_state_e typedef, and mode encoding constants.
REQ-031 Per-lane modular add/sub/overwrite SHALL be sub-module acc_lane_alu, instantiated LANES times via generate.
REQ-032 RAM SHALL be simple dual-port, read-first, 1-cycle registered read.

Verification
REQ-033 Overwrite 0x10 with 100 in every lane, add 50 -> read 0x10 returns 150 in every lane, rd_valid 2 cycles after rd_en.
REQ-034 Overwrite 0x50=0, then 4 consecutive-cycle adds of 10 -> 0x50 = 40 per lane.
REQ-035 LOG_Q=15: lane 0xFFFF overwrite stores 0x7FFF; add 1 -> 0x0000; subtract 1 from 0 -> 0x7FFF.
REQ-036 Alternating adds to 0x10 (+10, +5) and 0x20 (+20) on consecutive cycles -> 0x10 +15, 0x20 +20.
REQ-037 clear_start after random writes -> wr_ready low for depth+1 cycles; every address then reads 0; writes during clear are not accepted.
REQ-038 rstn pulse mid-clear -> clear_busy 0 immediately; wr_ready 1 after release.
